fifo_dispatcher: RTL and testbench

Read-side consumer for the 10-bit `fifo` block: drains words from the FIFO, decodes the destination field `[9:8]`, and delivers the 8-bit payload `[7:0]` to one of four downstream ports. It sits between the FIFO's read interface and the per-destination output FIFOs. It respects each downstream port's `almost_full` back-pressure, and it keeps a wrapping count of delivered words and a sticky error flag.

---
 rtl/fifo_dispatcher_if.sv | 35 +++
 rtl/fifo_dispatcher.sv | 110 +++++++++++
 tb/tb_fifo_dispatcher.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_dispatcher_if.sv
// Read-side FIFO port plus the four downstream write ports of the dispatcher.
// The slave modport is the dispatcher; the master modport is the surrounding FIFO/sink logic.
interface fifo_dispatcher_if #(
  parameter int WORD_SIZE = 10,
  parameter int DATA_SIZE = 8,
  parameter int NUM_DEST  = 4
);
  logic                 fifo_empty;
  logic                 fifo_error;
  logic [WORD_SIZE-1:0] fifo_data_out;
  logic                 fifo_rd;
  logic [NUM_DEST-1:0]  dest_almost_full;
  logic [NUM_DEST-1:0]  dest_wr;
  logic [DATA_SIZE-1:0] dest_data;

  modport slave (
    input  fifo_empty,
    input  fifo_error,
    input  fifo_data_out,
    input  dest_almost_full,
    output fifo_rd,
    output dest_wr,
    output dest_data
  );

  modport master (
    output fifo_empty,
    output fifo_error,
    output fifo_data_out,
    output dest_almost_full,
    input  fifo_rd,
    input  dest_wr,
    input  dest_data
  );
endinterface

// File: rtl/fifo_dispatcher.sv
// Drains 10-bit FIFO words and routes the 8-bit payload to one of four ports chosen by bits [9:8],
// honouring per-port almost_full, counting deliveries and keeping a sticky error flag.
module fifo_dispatcher #(
  parameter int WORD_SIZE = 10,
  parameter int DATA_SIZE = 8,
  parameter int NUM_DEST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  fifo_dispatcher_if.slave    bus,
  output logic                busy,
  output logic [7:0]          dispatch_count,
  output logic                error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic [7:0]           count_q, count_d;
  logic                 fifo_rd_q, fifo_rd_d;
  logic                 busy_q, busy_d;
  logic                 error_q, error_d;
  logic                 start_s;
  logic                 dest_ready_s;
  logic [1:0]           dest_s;
  logic [NUM_DEST-1:0]  dest_wr_s;

  function automatic logic [NUM_DEST-1:0] onehot(input logic [1:0] idx);
    logic [NUM_DEST-1:0] vec;
    vec      = {NUM_DEST{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Next-state, datapath and output-register inputs.
  always_comb begin
    dest_s       = word_q[WORD_SIZE-1 -: 2];
    // Destination is unknown before the read, so starting requires every port to be ready.
    start_s      = enable && !bus.fifo_empty && (bus.dest_almost_full == {NUM_DEST{1'b0}});
    dest_ready_s = !bus.dest_almost_full[dest_s];
    state_d      = state_q;
    word_d       = word_q;
    count_d      = count_q;
    error_d      = error_q | bus.fifo_error | ((state_q == POP) && bus.fifo_empty);
    if ((state_q == SEND) && dest_ready_s) begin
      dest_wr_s = onehot(dest_s);
    end else begin
      dest_wr_s = {NUM_DEST{1'b0}};
    end
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = POP;
        end else begin
          state_d = IDLE;
        end
      end
      POP: state_d = CAPTURE;
      CAPTURE: begin
        word_d  = bus.fifo_data_out;
        state_d = SEND;
      end
      SEND: begin
        if (dest_ready_s) begin
          count_d = count_q + 8'd1;
          state_d = start_s ? POP : IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    fifo_rd_d = (state_d == POP);
    busy_d    = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      word_q    <= {WORD_SIZE{1'b0}};
      count_q   <= 8'd0;
      fifo_rd_q <= 1'b0;
      busy_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      count_q   <= count_d;
      fifo_rd_q <= fifo_rd_d;
      busy_q    <= busy_d;
      error_q   <= error_d;
    end
  end

  assign bus.fifo_rd     = fifo_rd_q;
  assign bus.dest_wr     = dest_wr_s;
  assign bus.dest_data   = word_q[DATA_SIZE-1:0];
  assign busy            = busy_q;
  assign dispatch_count  = count_q;
  assign error           = error_q;

endmodule

// File: tb/tb_fifo_dispatcher.sv
// Directed testbench for fifo_dispatcher: the bench plays the FIFO and the sinks cycle by cycle
// and checks outputs 1 ns after each rising edge against hand-computed values.
module tb_fifo_dispatcher;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       busy;
  logic [7:0] dispatch_count;
  logic       error;
  int         vectors;
  int         miscompares;
  int         pulses;

  fifo_dispatcher_if #(.WORD_SIZE(10), .DATA_SIZE(8), .NUM_DEST(4)) bus ();

  fifo_dispatcher #(.WORD_SIZE(10), .DATA_SIZE(8), .NUM_DEST(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .bus            (bus.slave),
    .busy           (busy),
    .dispatch_count (dispatch_count),
    .error          (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [9:0] words [4];
    words[0] = 10'h011;
    words[1] = 10'h122;
    words[2] = 10'h233;
    words[3] = 10'h344;
    vectors = 0;
    miscompares = 0;
    pulses = 0;
    clk = 1'b0;
    reset = 1'b0;
    enable = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_error = 1'b0;
    bus.fifo_data_out = 10'h000;
    bus.dest_almost_full = 4'b0000;

    // Reset state
    tick();
    tick();
    chk("rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
    chk("rst_dest_wr", 32'(bus.dest_wr), 32'd0);
    chk("rst_dest_data", 32'(bus.dest_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(dispatch_count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b1;

    // Single word 10'b10_1010_0101 -> dest 2, payload A5
    enable = 1'b1;
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h2A5;
    tick();
    chk("single_pop_rd", 32'(bus.fifo_rd), 32'd1);
    chk("single_pop_busy", 32'(busy), 32'd1);
    chk("single_pop_wr", 32'(bus.dest_wr), 32'd0);
    tick();
    bus.fifo_empty = 1'b1;
    chk("single_cap_rd", 32'(bus.fifo_rd), 32'd0);
    chk("single_cap_wr", 32'(bus.dest_wr), 32'd0);
    tick();
    chk("single_send_wr", 32'(bus.dest_wr), 32'h4);
    chk("single_send_data", 32'(bus.dest_data), 32'hA5);
    chk("single_send_cnt", 32'(dispatch_count), 32'd0);
    tick();
    chk("single_done_cnt", 32'(dispatch_count), 32'd1);
    chk("single_done_busy", 32'(busy), 32'd0);
    chk("single_done_wr", 32'(bus.dest_wr), 32'd0);
    chk("single_done_err", 32'(error), 32'd0);

    // Burst: one word per destination, 3 cycles apart
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = words[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("burst_pop_rd", 32'(bus.fifo_rd), 32'd1);
      chk("burst_pop_wr", 32'(bus.dest_wr), 32'd0);
      tick();
      if (i == 3) bus.fifo_empty = 1'b1;
      chk("burst_cap_rd", 32'(bus.fifo_rd), 32'd0);
      chk("burst_cap_wr", 32'(bus.dest_wr), 32'd0);
      tick();
      chk("burst_send_wr", 32'(bus.dest_wr), 32'(4'b0001 << i));
      chk("burst_send_data", 32'(bus.dest_data), 32'(8'h11 * (i + 1)));
      if (i < 3) bus.fifo_data_out = words[i+1];
      tick();
    end
    chk("burst_cnt", 32'(dispatch_count), 32'd5);
    chk("burst_busy", 32'(busy), 32'd0);

    // Back-pressure on dest 3 raised during CAPTURE and held 5 cycles
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h3C7;
    tick();
    tick();
    bus.fifo_empty = 1'b1;
    bus.dest_almost_full = 4'b1000;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_wr", 32'(bus.dest_wr), 32'd0);
      chk("bp_hold_busy", 32'(busy), 32'd1);
      tick();
    end
    bus.dest_almost_full = 4'b0000;
    #1;
    chk("bp_release_wr", 32'(bus.dest_wr), 32'h8);
    chk("bp_release_data", 32'(bus.dest_data), 32'hC7);
    tick();
    chk("bp_cnt", 32'(dispatch_count), 32'd6);
    chk("bp_busy", 32'(busy), 32'd0);

    // Start is blocked while any port is almost full
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h0F0;
    bus.dest_almost_full = 4'b0010;
    tick();
    tick();
    chk("block_rd", 32'(bus.fifo_rd), 32'd0);
    chk("block_busy", 32'(busy), 32'd0);
    bus.dest_almost_full = 4'b0000;
    tick();
    chk("unblock_rd", 32'(bus.fifo_rd), 32'd1);
    tick();
    bus.fifo_empty = 1'b1;
    tick();
    chk("unblock_wr", 32'(bus.dest_wr), 32'h1);
    chk("unblock_data", 32'(bus.dest_data), 32'hF0);
    tick();
    chk("unblock_cnt", 32'(dispatch_count), 32'd7);

    // enable low with data available: no read
    enable = 1'b0;
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h1AB;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_low_rd", 32'(bus.fifo_rd), 32'd0);
    end
    // enable dropped during CAPTURE: word still delivered, no further reads
    enable = 1'b1;
    tick();
    chk("en_drop_pop_rd", 32'(bus.fifo_rd), 32'd1);
    tick();
    enable = 1'b0;
    tick();
    chk("en_drop_wr", 32'(bus.dest_wr), 32'h2);
    chk("en_drop_data", 32'(bus.dest_data), 32'hAB);
    tick();
    chk("en_drop_busy", 32'(busy), 32'd0);
    chk("en_drop_cnt", 32'(dispatch_count), 32'd8);
    tick();
    chk("en_drop_rd", 32'(bus.fifo_rd), 32'd0);
    // Empty FIFO with enable high: stays idle, no error
    enable = 1'b1;
    bus.fifo_empty = 1'b1;
    tick();
    tick();
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_rd", 32'(bus.fifo_rd), 32'd0);
    chk("empty_err", 32'(error), 32'd0);

    // Reset asserted during CAPTURE
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h2EE;
    tick();
    tick();
    bus.fifo_empty = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst_rd", 32'(bus.fifo_rd), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cnt", 32'(dispatch_count), 32'd0);
    chk("midrst_data", 32'(bus.dest_data), 32'd0);
    tick();
    chk("midrst_wr", 32'(bus.dest_wr), 32'd0);
    reset = 1'b1;
    tick();
    chk("midrst_after_wr", 32'(bus.dest_wr), 32'd0);
    chk("midrst_after_busy", 32'(busy), 32'd0);

    // Empty FIFO during POP flags an error but the word is still delivered
    bus.fifo_empty = 1'b0;
    bus.fifo_data_out = 10'h155;
    tick();
    bus.fifo_empty = 1'b1;
    tick();
    chk("popempty_err", 32'(error), 32'd1);
    tick();
    chk("popempty_wr", 32'(bus.dest_wr), 32'h2);
    chk("popempty_data", 32'(bus.dest_data), 32'h55);
    tick();
    chk("popempty_cnt", 32'(dispatch_count), 32'd1);
    reset = 1'b0;
    #1;
    chk("err_clear", 32'(error), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // fifo_error pulse is sticky
    bus.fifo_error = 1'b1;
    tick();
    bus.fifo_error = 1'b0;
    chk("ferr_set", 32'(error), 32'd1);
    tick();
    tick();
    chk("ferr_sticky", 32'(error), 32'd1);

    // 256 back-to-back words wrap the counter to 0
    bus.fifo_data_out = 10'h000;
    bus.fifo_empty = 1'b0;
    tick();
    for (int k = 0; k < 765; k++) begin
      tick();
      if (bus.dest_wr != 4'b0000) pulses++;
    end
    chk("wrap_cnt_255", 32'(dispatch_count), 32'd255);
    tick();
    bus.fifo_empty = 1'b1;
    tick();
    if (bus.dest_wr != 4'b0000) pulses++;
    tick();
    chk("wrap_cnt_0", 32'(dispatch_count), 32'd0);
    chk("wrap_pulses", 32'(pulses), 32'd256);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_err_sticky", 32'(error), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
